// File: rtl/dpram_rmw_master.sv
// Bus-side initiator for one port of the dual-port block RAM: byte-lane writes
// via read-modify-write, latency-aligned read capture, and a whole-RAM fill engine.
module dpram_rmw_master #(
  parameter int addr_width = 8,
  parameter int data_width = 16,
  parameter int lanes      = data_width / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  wr,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wdata,
  input  logic [lanes-1:0]      be,
  output logic [data_width-1:0] rdata,
  output logic                  ack,
  output logic                  busy,
  input  logic                  fill_start,
  input  logic [data_width-1:0] fill_value,
  output logic                  fill_done,
  output logic [addr_width-1:0] ram_address,
  output logic [data_width-1:0] ram_data,
  output logic                  ram_enable,
  output logic                  ram_cs,
  output logic                  ram_wren,
  input  logic [data_width-1:0] ram_q,
  output logic [2:0]            state_dbg
);

  // Handshake: req/fill_start are single-cycle strobes taken only while busy=0
  // (busy acts as not-ready); anything strobed while busy=1 is dropped, and each
  // accepted request completes with exactly one ack (or fill_done) pulse.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    ACK     = 3'd4,
    FILL    = 3'd5
  } state_t;

  state_t                state;
  logic                  req_wr;
  logic [data_width-1:0] req_wdata;
  logic [lanes-1:0]      req_be;
  logic                  fill_pend;
  logic [data_width-1:0] fill_word;
  logic [data_width-1:0] merged;

  assign state_dbg = state;

  // Enabled lanes take the new write data, the rest keep what the RAM returned.
  always_comb begin
    merged = ram_q;
    for (int i = 0; i < lanes; i++) begin
      if (req_be[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_wr      <= 1'b0;
      req_wdata   <= '0;
      req_be      <= '0;
      fill_pend   <= 1'b0;
      fill_word   <= '0;
      rdata       <= '0;
      ack         <= 1'b0;
      busy        <= 1'b0;
      fill_done   <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_enable  <= 1'b0;
      ram_cs      <= 1'b0;
      ram_wren    <= 1'b0;
    end else begin
      ack       <= 1'b0;
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            busy      <= 1'b1;
            req_wr    <= wr;
            req_wdata <= wdata;
            req_be    <= be;
            if (fill_start) begin
              fill_pend <= 1'b1;
              fill_word <= fill_value;
            end
            if (wr && be == '0) begin
              ack   <= 1'b1;
              state <= ACK;
            end else if (wr && (&be)) begin
              ram_address <= addr;
              ram_data    <= wdata;
              ram_wren    <= 1'b1;
              ram_enable  <= 1'b1;
              ram_cs      <= 1'b1;
              state       <= WR;
            end else begin
              // Reads and partial writes both start with a RAM read.
              ram_address <= addr;
              ram_enable  <= 1'b1;
              ram_cs      <= 1'b1;
              state       <= RD_ADDR;
            end
          end else if (fill_start) begin
            busy        <= 1'b1;
            ram_address <= '0;
            ram_data    <= fill_value;
            ram_wren    <= 1'b1;
            ram_enable  <= 1'b1;
            ram_cs      <= 1'b1;
            state       <= FILL;
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          if (req_wr) begin
            ram_data <= merged;
            ram_wren <= 1'b1;
            state    <= WR;
          end else begin
            rdata      <= ram_q;
            ack        <= 1'b1;
            ram_enable <= 1'b0;
            ram_cs     <= 1'b0;
            state      <= ACK;
          end
        end
        WR: begin
          ram_wren   <= 1'b0;
          ram_enable <= 1'b0;
          ram_cs     <= 1'b0;
          ack        <= 1'b1;
          state      <= ACK;
        end
        ACK: begin
          // A fill queued alongside the request follows with no idle gap.
          if (fill_pend) begin
            fill_pend   <= 1'b0;
            ram_address <= '0;
            ram_data    <= fill_word;
            ram_wren    <= 1'b1;
            ram_enable  <= 1'b1;
            ram_cs      <= 1'b1;
            state       <= FILL;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        FILL: begin
          if (ram_address == {addr_width{1'b1}}) begin
            ram_wren   <= 1'b0;
            ram_enable <= 1'b0;
            ram_cs     <= 1'b0;
            fill_done  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            ram_address <= ram_address + addr_width'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_rmw_master.sv
// Bench for dpram_rmw_master: behavioural RAM, directed vector table, fill and
// reset sequences, then random traffic checked against an array model.
module tb_dpram_rmw_master;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LN = 2;
  localparam int NV = 14;

  logic          clock, reset_n, req, wr, ack, busy, fill_start, fill_done;
  logic [AW-1:0] addr, ram_address;
  logic [DW-1:0] wdata, rdata, fill_value, ram_data, ram_q;
  logic [LN-1:0] be;
  logic          ram_enable, ram_cs, ram_wren;
  logic [2:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  dpram_rmw_master #(.addr_width(AW), .data_width(DW)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata), .ack(ack), .busy(busy),
    .fill_start(fill_start), .fill_value(fill_value), .fill_done(fill_done),
    .ram_address(ram_address), .ram_data(ram_data), .ram_enable(ram_enable),
    .ram_cs(ram_cs), .ram_wren(ram_wren), .ram_q(ram_q), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Block RAM port: registered address, new-data read-during-write.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_areg;
  always @(posedge clock) begin
    if (ram_enable && ram_cs) begin
      if (ram_wren) ram_mem[ram_address] <= ram_data;
      ram_areg <= ram_address;
    end
  end
  assign ram_q = ram_mem[ram_areg];

  // reference model
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_rd;

  function automatic int exp_lat(input logic w, input logic [LN-1:0] b);
    if (!w) return 3;
    if (b == '0) return 1;
    if (b == '1) return 2;
    return 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [LN-1:0] b, input logic fs, input logic [DW-1:0] fv,
                       output int lat, output logic [DW-1:0] rd, output int wn,
                       output int en, output logic bok);
    lat = 0; wn = 0; en = 0; bok = 1'b1; rd = '0;
    @(negedge clock);
    req = 1'b1; wr = w; addr = a; wdata = d; be = b; fill_start = fs; fill_value = fv;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      req = 1'b0; fill_start = 1'b0;
      if (ram_wren) wn++;
      if (ram_enable) en++;
      if (!busy) bok = 1'b0;
      if (ack) begin
        lat = c;
        rd  = rdata;
        break;
      end
    end
  endtask

  task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    int lat, wn, en;
    logic [DW-1:0] rd;
    logic bok;
    do_op(1'b0, a, '0, '0, 1'b0, '0, lat, rd, wn, en, bok);
    check({name, "_lat"}, lat, 3);
    check({name, "_rdata"}, rd, exp);
  endtask

  // Samples from the current negedge until fill_done or the cycle budget runs out.
  task automatic watch_fill(input logic mid_req, output int wn, output int aerr,
                            output int acks, output int gaps, output logic done);
    int exp_a;
    exp_a = 0; wn = 0; aerr = 0; acks = 0; gaps = 0; done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (fill_done) begin
        done = 1'b1;
        break;
      end
      if (ram_wren) begin
        wn++;
        if (ram_address != exp_a[AW-1:0]) aerr++;
        exp_a++;
      end
      if (ack) acks++;
      if (!busy) gaps++;
      if (mid_req && c == 100) begin
        req = 1'b1; wr = 1'b0; addr = 8'h05;
      end else begin
        req = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  task automatic fill_checks(input string name, input logic [DW-1:0] v);
    int wn, aerr, acks, gaps;
    logic done;
    watch_fill(1'b1, wn, aerr, acks, gaps, done);
    check({name, "_done"}, done, 1);
    check({name, "_wren_cycles"}, wn, 256);
    check({name, "_addr_seq_err"}, aerr, 0);
    check({name, "_ack_during_fill"}, acks, 0);
    check({name, "_busy_gap"}, gaps, 0);
    check({name, "_wren_at_done"}, ram_wren, 0);
    @(negedge clock);
    check({name, "_done_single"}, fill_done, 0);
    check({name, "_no_late_ack"}, ack, 0);
    check({name, "_busy_after"}, busy, 0);
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = v;
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [LN-1:0] b;
    logic [DW-1:0] exp_rd;
    int            exp_lat;
    int            exp_wren;
    int            exp_en;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int lat, wn, en, cnt, dn;
    logic [DW-1:0] rd;
    logic bok, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [LN-1:0] b;

    // write/read vectors; rdata must hold the last read value across writes
    vecs[0]  = '{1'b1, 8'h12, 16'hBEEF, 2'b11, 16'h0000, 2, 1, 1};
    vecs[1]  = '{1'b0, 8'h12, 16'h0000, 2'b00, 16'hBEEF, 3, 0, 2};
    vecs[2]  = '{1'b1, 8'h12, 16'h55AA, 2'b01, 16'hBEEF, 4, 1, 3};
    vecs[3]  = '{1'b0, 8'h12, 16'h0000, 2'b00, 16'hBEAA, 3, 0, 2};
    vecs[4]  = '{1'b1, 8'h12, 16'h1234, 2'b00, 16'hBEAA, 1, 0, 0};
    vecs[5]  = '{1'b0, 8'h12, 16'h0000, 2'b11, 16'hBEAA, 3, 0, 2};
    vecs[6]  = '{1'b1, 8'h13, 16'hC0DE, 2'b11, 16'hBEAA, 2, 1, 1};
    vecs[7]  = '{1'b1, 8'h13, 16'h7711, 2'b10, 16'hBEAA, 4, 1, 3};
    vecs[8]  = '{1'b0, 8'h13, 16'h0000, 2'b00, 16'h77DE, 3, 0, 2};
    vecs[9]  = '{1'b1, 8'hFF, 16'h0F0F, 2'b11, 16'h77DE, 2, 1, 1};
    vecs[10] = '{1'b1, 8'h00, 16'hA1B2, 2'b11, 16'h77DE, 2, 1, 1};
    vecs[11] = '{1'b0, 8'hFF, 16'h0000, 2'b00, 16'h0F0F, 3, 0, 2};
    vecs[12] = '{1'b1, 8'h00, 16'hFFFF, 2'b10, 16'h0F0F, 4, 1, 3};
    vecs[13] = '{1'b0, 8'h00, 16'h0000, 2'b00, 16'hFFB2, 3, 0, 2};

    reset_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
    fill_start = 1'b0; fill_value = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs_zero",
          {rdata, ack, busy, fill_done, ram_address, ram_data, ram_enable, ram_cs, ram_wren, state_dbg}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, 1'b0, '0, lat, rd, wn, en, bok);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_wren", i), wn, vecs[i].exp_wren);
      check($sformatf("vec%0d_enable", i), en, vecs[i].exp_en);
      check($sformatf("vec%0d_busy", i), bok, 1);
      @(negedge clock);
      check($sformatf("vec%0d_idle_after", i), busy, 0);
    end

    // standalone fill with a request strobed mid-fill
    @(negedge clock);
    fill_start = 1'b1; fill_value = 16'hA5A5;
    @(negedge clock);
    fill_start = 1'b0;
    fill_checks("fill1", 16'hA5A5);
    read_chk(8'h00, 16'hA5A5, "fill1_rd00");
    read_chk(8'h7F, 16'hA5A5, "fill1_rd7f");
    read_chk(8'hFF, 16'hA5A5, "fill1_rdff");
    read_chk(8'h05, 16'hA5A5, "fill1_rd05");

    // read and fill_start together: read first, fill right after the ack
    do_op(1'b0, 8'h40, '0, '0, 1'b1, 16'h1234, lat, rd, wn, en, bok);
    check("simul_read_lat", lat, 3);
    check("simul_read_rdata", rd, model_mem[8'h40]);
    check("simul_busy", bok, 1);
    @(negedge clock);
    check("simul_fill_start_wren", ram_wren, 1);
    check("simul_fill_start_addr", ram_address, 0);
    check("simul_fill_start_data", ram_data, 16'h1234);
    check("simul_fill_start_busy", busy, 1);
    fill_checks("fill2", 16'h1234);
    read_chk(8'h40, 16'h1234, "fill2_rd40");

    // random traffic against the array model
    last_rd = 16'h1234;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'h20 + 8'($urandom_range(0, 7));
      d = 16'($urandom);
      b = 2'($urandom_range(0, 3));
      do_op(w, a, d, b, 1'b0, '0, lat, rd, wn, en, bok);
      if (w) begin
        for (int l = 0; l < LN; l++) if (b[l]) model_mem[a][8*l +: 8] = d[8*l +: 8];
      end else begin
        last_rd = model_mem[a];
      end
      check($sformatf("rnd%0d_lat", i), lat, exp_lat(w, b));
      check($sformatf("rnd%0d_rdata", i), rd, last_rd);
      check($sformatf("rnd%0d_wren", i), wn, (w && b != '0) ? 1 : 0);
      check($sformatf("rnd%0d_enable", i), en, exp_lat(w, b) - 1);
    end

    // reset while a partial write is reading its old word
    do_op(1'b1, 8'h30, 16'h1111, 2'b11, 1'b0, '0, lat, rd, wn, en, bok);
    model_mem[8'h30] = 16'h1111;
    check("rstA_prewrite_lat", lat, 2);
    @(negedge clock);
    req = 1'b1; wr = 1'b1; addr = 8'h30; wdata = 16'hFFFF; be = 2'b01;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rstA_outputs_zero",
          {rdata, ack, busy, fill_done, ram_address, ram_data, ram_enable, ram_cs, ram_wren, state_dbg}, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clock);
      if (ack || ram_wren) cnt++;
    end
    reset_n = 1'b1;
    @(negedge clock);
    check("rstA_no_ack_or_write", cnt, 0);
    check("rstA_busy_after", busy, 0);
    check("rstA_ram_unchanged", ram_mem[8'h30], 16'h1111);
    read_chk(8'h30, 16'h1111, "rstA_rd30");

    // reset part-way through a fill
    @(negedge clock);
    fill_start = 1'b1; fill_value = 16'h5A5A;
    @(negedge clock);
    fill_start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (ram_wren) cnt++;
      if (c < 39) @(negedge clock);
    end
    reset_n = 1'b0;
    #1;
    check("rstB_wren_drops", {ram_wren, ram_enable, busy}, 0);
    check("rstB_write_count", cnt, 40);
    for (int i = 0; i < cnt - 1; i++) model_mem[i] = 16'h5A5A;
    check("rstB_last_written", ram_mem[cnt - 2], 16'h5A5A);
    check("rstB_abandoned_addr", ram_mem[cnt - 1], model_mem[cnt - 1]);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    dn = 0; wn = 0;
    repeat (300) begin
      @(negedge clock);
      if (fill_done) dn++;
      if (ram_wren) wn++;
    end
    check("rstB_no_fill_done", dn, 0);
    check("rstB_no_more_writes", wn, 0);
    read_chk(8'h00, 16'h5A5A, "rstB_rd00");
    read_chk(8'(cnt - 1), model_mem[cnt - 1], "rstB_rd_abandoned");
    read_chk(8'h80, model_mem[8'h80], "rstB_rd80");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_rmw_master.md
Name: dpram_rmw_master

Overview:
- Single-port initiator that drives one port of the team's true dual-port block RAM on behalf of a simple strobe-based CPU/DMA request interface.
- The RAM has no byte enables and has a one-clock registered-address read latency. This block adds:
  - byte-lane writes, implemented as read-modify-write;
  - read-data capture timed to that latency;
  - a hardware fill engine that initialises the whole RAM to a constant.
- Sits between a bus client and port A or port B of the RAM; the other RAM port stays free for video/DMA.

Parameters:
- addr_width, 8, RAM address width; depth = 2^addr_width words.
- data_width, 16, word width; must be a multiple of 8.
- lanes, data_width/8, byte-lane count (derived; do not override).

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  single-cycle request strobe; accepted only when busy=0.
- wr  in  1  1=write, 0=read; sampled with req.
- addr  in  addr_width  request word address; sampled with req.
- wdata  in  data_width  write data; sampled with req.
- be  in  lanes  byte enables, bit i covers wdata[8i+7:8i]; sampled with req.
- rdata  out  data_width  read result; valid while ack=1, held until next read completes.
- ack  out  1  one-cycle completion pulse for reads and writes.
- busy  out  1  high from the cycle after acceptance through the ack cycle inclusive, and throughout fill.
- fill_start  in  1  single-cycle strobe to begin fill.
- fill_value  in  data_width  fill word; sampled with fill_start.
- fill_done  out  1  one-cycle pulse when fill completes.
- ram_address  out  addr_width  to RAM address.
- ram_data  out  data_width  to RAM write data.
- ram_enable  out  1  to RAM clock enable.
- ram_cs  out  1  to RAM chip select.
- ram_wren  out  1  to RAM write enable.
- ram_q  in  data_width  from RAM read data; unregistered output of the registered address.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending fill cleared.
- Reset mid-operation:
  - outputs drop immediately, since reset is asynchronous;
  - any in-flight write is abandoned; the RAM contents at that address are undefined only if reset coincides with the write edge;
  - no ack or fill_done is issued for the abandoned operation.
- All ram_* outputs are registered.
  - ram_enable and ram_cs are 1 only in access states and 0 in IDLE.
  - ram_wren is 1 for exactly one cycle per write access, except during FILL.
- States: IDLE, RD_ADDR, RD_DATA, WR, ACK, FILL.
- Cycle timing is referenced to E0, the edge that samples req=1 in IDLE.
- Read (wr=0):
  - At E0, ram_address<=addr and ram_enable/ram_cs<=1 (RD_ADDR).
  - At E1 the RAM registers the address (RD_DATA).
  - At E2, rdata<=ram_q and ack<=1 (ACK).
  - ack is high in the cycle after E2, i.e. 3 cycles after the req cycle.
  - At E3 the FSM returns to IDLE.
- Full write (be all ones):
  - At E0, ram_address/ram_data<=addr/wdata and ram_wren<=1 (WR).
  - At E1 the RAM writes, ram_wren<=0, ack<=1.
  - At E2 the FSM returns to IDLE.
- Partial write (be neither all ones nor zero):
  - Performs the read sequence through E2.
  - At E2, instead of acking, ram_data<=merge and ram_wren<=1. For each lane i, merge lane i = be[i] ? wdata lane i : ram_q lane i.
  - At E3 the RAM writes and ack<=1.
  - rdata is not updated by a write.
- be all zero: no RAM access; ack is asserted in the cycle after E0.
- req while busy=1 is ignored and dropped; the requester must check busy.
- fill_start in IDLE:
  - latch fill_value;
  - ram_address<=0, ram_wren/ram_enable/ram_cs<=1, enter FILL.
- FILL:
  - each edge increments ram_address, so 2^addr_width consecutive write cycles;
  - after the edge that writes address 2^addr_width-1: ram_wren<=0, fill_done<=1 for one cycle, return to IDLE;
  - the address counter must not wrap into a second pass.
- req and fill_start in the same IDLE cycle: req wins.
  - The fill is latched as pending with its fill_value and starts in the cycle after ack.
  - busy stays high across the gap.
- fill_start while busy and not pending: ignored.
- Reads immediately following writes to the same address return the new data; the RAM provides new-data read-during-write and the FSM imposes no bypass.

Test Plan:
- Full write then read: write addr 0x12 with wdata 0xBEEF and be=11, then read 0x12.
  - Write ack is 1 cycle after accept; ram_wren is high for exactly 1 cycle.
  - Read ack is 3 cycles after the req cycle, with rdata=0xBEEF.
- Byte-lane RMW: preload 0x12=0xBEEF, write wdata 0x55AA with be=01, then read 0x12.
  - rdata=0xBEAA; write ack is 4 cycles after the req cycle; exactly one RAM write.
- be=00 write to 0x12: ack the cycle after accept, ram_enable never asserted, contents still 0xBEAA.
- Fill: fill_start with fill_value 0xA5A5.
  - ram_wren is high for exactly 256 cycles covering addresses 0..255, followed by a single fill_done pulse.
  - Reads of 0x00, 0x7F and 0xFF all return 0xA5A5.
  - A req issued mid-fill is ignored: no ack, no corruption.
- Simultaneous req (read 0x40) and fill_start (0x1234):
  - read acks first with the pre-fill data;
  - fill starts the cycle after ack; busy is continuous until fill_done; afterwards 0x40 reads 0x1234.
- Reset mid-operation:
  - Assert reset_n=0 during RD_DATA of a partial write. All outputs go to 0 asynchronously; no ack; no RAM write occurs.
  - After release, busy=0 and a new read completes normally.
  - Reset during FILL stops writes immediately, and fill_done is never pulsed.
